// File: rtl/mul_cpa_pipe_if.sv
// Stream bundle for the final carry-propagate adder: redundant sum/carry in, binary product out.
// master = compressor tree / consumer side, slave = the adder pipeline.
interface mul_cpa_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_sum, in_carry, in_cin, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_cout, out_tag
  );

  modport slave (
    input  in_valid, in_sum, in_carry, in_cin, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_cout, out_tag
  );
endinterface

// File: rtl/mul_cpa_pipe.sv
// Two-stage carry-lookahead adder closing the multiplier datapath.
// s1 forms bit/group/block propagate-generate; s2 resolves carries top-down and sums.
module mul_cpa_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  mul_cpa_pipe_if.slave bus
);
  localparam int NG = WIDTH / 4;
  localparam int NB = WIDTH / 16;

  // {P, G} of a 4-cell lookahead group
  function automatic logic [1:0] pg4(input logic [3:0] p, input logic [3:0] g);
    logic [1:0] r;
    r[1] = &p;
    r[0] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

  // Carries into the 4 cells of a group; the top cell's P/G are not needed here.
  function automatic logic [3:0] la4c(input logic [2:0] p, input logic [2:0] g, input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // handshake
  logic s1_v_d, s1_v_q, s2_v_d, s2_v_q;
  logic s2_adv, in_ready, accept;

  always_comb begin
    s2_adv   = !s2_v_q | bus.out_ready;
    in_ready = !s1_v_q | s2_adv;
    accept   = bus.in_valid & in_ready & !flush;
    s1_v_d   = s1_v_q;
    s2_v_d   = s2_v_q;
    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end else begin
      if (accept)      s1_v_d = 1'b1;
      else if (s2_adv) s1_v_d = 1'b0;
      if (s2_adv)      s2_v_d = s1_v_q;
    end
  end

  // stage 1: propagate/generate at bit, group and block level
  logic [WIDTH-1:0]       a_p, a_g;
  logic [NG-1:0]          gp, gg;
  logic [NB-1:0]          bp_n, bg_n;
  logic [WIDTH-1:0]       p_d, p_q;
  // Top-cell generates only feed the group/block G already registered, so drop them.
  logic [NG-1:0][2:0]     gl_d, gl_q;
  logic [NB-1:0][2:0]     gpl_d, gpl_q, ggl_d, ggl_q;
  logic [NB-1:0]          bp_d, bp_q, bg_d, bg_q;
  logic                   cin_d, cin_q;
  logic [TAG_W-1:0]       tag1_d, tag1_q;

  always_comb begin
    a_p = bus.in_sum ^ bus.in_carry;
    a_g = bus.in_sum & bus.in_carry;
    for (int j = 0; j < NG; j++) {gp[j], gg[j]} = pg4(a_p[4*j +: 4], a_g[4*j +: 4]);
    for (int b = 0; b < NB; b++) {bp_n[b], bg_n[b]} = pg4(gp[4*b +: 4], gg[4*b +: 4]);

    p_d    = p_q;
    gl_d   = gl_q;
    gpl_d  = gpl_q;
    ggl_d  = ggl_q;
    bp_d   = bp_q;
    bg_d   = bg_q;
    cin_d  = cin_q;
    tag1_d = tag1_q;
    if (accept) begin
      p_d = a_p;
      for (int j = 0; j < NG; j++) gl_d[j] = a_g[4*j +: 3];
      for (int b = 0; b < NB; b++) begin
        gpl_d[b] = gp[4*b +: 3];
        ggl_d[b] = gg[4*b +: 3];
      end
      bp_d   = bp_n;
      bg_d   = bg_n;
      cin_d  = bus.in_cin;
      tag1_d = bus.in_tag;
    end
  end

  // stage 2: block -> group -> bit carries, each a flat lookahead from its carry-in
  logic [NB:0]            bc;
  logic [NG-1:0]          gc;
  logic [WIDTH-1:0]       c;
  logic [WIDTH-1:0]       res_d, res_q;
  logic                   cout_d, cout_q;
  logic [TAG_W-1:0]       tag2_d, tag2_q;

  always_comb begin
    for (int k = 0; k <= NB; k++) begin
      logic term, acc;
      term = cin_q;
      for (int m = 0; m < k; m++) term = term & bp_q[m];
      acc = term;
      for (int j = 0; j < k; j++) begin
        term = bg_q[j];
        for (int m = j + 1; m < k; m++) term = term & bp_q[m];
        acc = acc | term;
      end
      bc[k] = acc;
    end
    for (int b = 0; b < NB; b++) gc[4*b +: 4] = la4c(gpl_q[b], ggl_q[b], bc[b]);
    for (int j = 0; j < NG; j++) c[4*j +: 4] = la4c(p_q[4*j +: 3], gl_q[j], gc[j]);

    res_d  = res_q;
    cout_d = cout_q;
    tag2_d = tag2_q;
    if (s2_adv && s1_v_q) begin
      res_d  = p_q ^ c;
      cout_d = bc[NB];
      tag2_d = tag1_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
      tag2_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      res_q  <= res_d;
      cout_q <= cout_d;
      tag2_q <= tag2_d;
    end
  end

  always_ff @(posedge clock) begin
    p_q    <= p_d;
    gl_q   <= gl_d;
    gpl_q  <= gpl_d;
    ggl_q  <= ggl_d;
    bp_q   <= bp_d;
    bg_q   <= bg_d;
    cin_q  <= cin_d;
    tag1_q <= tag1_d;
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = s2_v_q;
  assign bus.out_result = res_q;
  assign bus.out_cout   = cout_q;
  assign bus.out_tag    = tag2_q;
endmodule

// File: tb/tb_mul_cpa_pipe.sv
// Directed + randomized bench for mul_cpa_pipe with a 65-bit reference model scoreboard.
module tb_mul_cpa_pipe;
  logic clock = 1'b0;
  logic reset, flush;
  int   n_chk = 0, n_fail = 0, cyc = 0;

  mul_cpa_pipe_if #(.WIDTH(64), .TAG_W(4)) bus ();
  mul_cpa_pipe #(.WIDTH(64), .TAG_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush), .bus(bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct packed { logic [64:0] val; logic [3:0] tag; } exp_t;
  exp_t        mq[$];
  logic [63:0] dlv_res[$];
  logic        dlv_cout[$];
  logic [3:0]  dlv_tag[$];
  int          dlv_cyc[$];

  // Reference model: transfers complete at the next rising edge, so sample at the falling edge.
  always @(negedge clock) begin
    if (reset) mq.delete();
    else begin
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        dlv_res.push_back(bus.out_result);
        dlv_cout.push_back(bus.out_cout);
        dlv_tag.push_back(bus.out_tag);
        dlv_cyc.push_back(cyc);
        chk("model_expected_entry", mq.size() != 0, 1);
        if (mq.size() != 0) begin
          e = mq.pop_front();
          chk("model_sum", {bus.out_cout, bus.out_result}, e.val);
          chk("model_tag", bus.out_tag, e.tag);
        end
      end
      if (flush) mq.delete();
      else if (bus.in_valid && bus.in_ready)
        mq.push_back('{val: {1'b0, bus.in_sum} + {1'b0, bus.in_carry} + 65'(bus.in_cin),
                       tag: bus.in_tag});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [63:0] s, input logic [63:0] cy, input logic ci, input logic [3:0] t);
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    bus.in_carry = cy;
    bus.in_cin   = ci;
    bus.in_tag   = t;
  endtask

  task automatic clear_dlv();
    dlv_res.delete(); dlv_cout.delete(); dlv_tag.delete(); dlv_cyc.delete();
  endtask

  logic [63:0] vs[6], vc[6], vr[6];
  logic        vi[6], vo[6];

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_sum = '0; bus.in_carry = '0; bus.in_cin = 1'b0; bus.in_tag = '0;
    step(); step();
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_result", bus.out_result, 0);
    chk("reset_out_cout", bus.out_cout, 0);
    chk("reset_out_tag", bus.out_tag, 0);
    reset = 1'b0;
    #1;
    chk("reset_in_ready", bus.in_ready, 1);

    // T1: all-propagate with carry-in, 2-cycle latency
    bus.out_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 4'd5);
    step();
    bus.in_valid = 1'b0;
    chk("t1_not_yet_valid", bus.out_valid, 0);
    step();
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_result", bus.out_result, 0);
    chk("t1_cout", bus.out_cout, 1);
    chk("t1_tag", bus.out_tag, 5);
    step();
    chk("t1_drained", bus.out_valid, 0);

    // hand-computed carry patterns, back to back
    vs[0] = 64'h8000_0000_0000_0000; vc[0] = 64'h8000_0000_0000_0000; vi[0] = 0;
    vr[0] = 64'h0;                   vo[0] = 1;
    vs[1] = 64'h0000_0000_FFFF_FFFF; vc[1] = 64'h1;                   vi[1] = 0;
    vr[1] = 64'h0000_0001_0000_0000; vo[1] = 0;
    vs[2] = 64'h0000_FFFF_0000_FFFF; vc[2] = 64'h0000_0001_0000_0001; vi[2] = 1;
    vr[2] = 64'h0001_0000_0001_0001; vo[2] = 0;
    vs[3] = 64'h0123_4567_89AB_CDEF; vc[3] = 64'hFEDC_BA98_7654_3210; vi[3] = 1;
    vr[3] = 64'h0;                   vo[3] = 1;
    vs[4] = 64'hFFFF_FFFF_FFFF_FFFF; vc[4] = 64'hFFFF_FFFF_FFFF_FFFF; vi[4] = 1;
    vr[4] = 64'hFFFF_FFFF_FFFF_FFFF; vo[4] = 1;
    vs[5] = 64'h1234;                vc[5] = 64'h0F0F;                vi[5] = 1;
    vr[5] = 64'h2144;                vo[5] = 0;
    clear_dlv();
    for (int k = 0; k < 6; k++) begin
      send(vs[k], vc[k], vi[k], 4'(6 + k));
      step();
    end
    bus.in_valid = 1'b0;
    step(); step(); step();
    chk("vec_count", dlv_res.size(), 6);
    for (int k = 0; k < 6 && k < dlv_res.size(); k++) begin
      chk($sformatf("vec%0d_result", k), dlv_res[k], vr[k]);
      chk($sformatf("vec%0d_cout", k), dlv_cout[k], vo[k]);
      chk($sformatf("vec%0d_tag", k), dlv_tag[k], 6 + k);
    end

    // T2: 8 back-to-back inputs give 8 results on consecutive cycles
    clear_dlv();
    for (int i = 0; i < 8; i++) begin
      send(64'(i), 64'(i) << 8, 1'b0, 4'(i));
      step();
    end
    bus.in_valid = 1'b0;
    step(); step(); step();
    chk("t2_count", dlv_res.size(), 8);
    for (int k = 0; k < 8 && k < dlv_res.size(); k++) begin
      chk($sformatf("t2_result%0d", k), dlv_res[k], 64'(k) + (64'(k) << 8));
      chk($sformatf("t2_tag%0d", k), dlv_tag[k], k);
      chk($sformatf("t2_cycle%0d", k), dlv_cyc[k] - dlv_cyc[0], k);
    end

    // T3: backpressure with both stages full
    clear_dlv();
    bus.out_ready = 1'b0;
    send(64'd100, 64'd200, 1'b0, 4'd1); step();
    send(64'hFFFF, 64'd1, 1'b0, 4'd2);  step();
    send(64'd7, 64'd8, 1'b1, 4'd3);
    #1;
    chk("t3_in_ready_full", bus.in_ready, 0);
    chk("t3_out_valid", bus.out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t3_hold_result%0d", k), bus.out_result, 64'd300);
      chk($sformatf("t3_hold_tag%0d", k), bus.out_tag, 1);
      chk($sformatf("t3_hold_in_ready%0d", k), bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t3_in_ready_release", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    step(); step(); step();
    chk("t3_count", dlv_res.size(), 3);
    if (dlv_res.size() == 3) begin
      chk("t3_res0", dlv_res[0], 64'd300);
      chk("t3_res1", dlv_res[1], 64'h10000);
      chk("t3_res2", dlv_res[2], 64'd16);
      chk("t3_tag2", dlv_tag[2], 3);
    end

    // T4: flush kills A and drops B; only C comes out
    clear_dlv();
    send(64'd1, 64'd1, 1'b0, 4'd1); step();
    send(64'd2, 64'd2, 1'b0, 4'd2); flush = 1'b1; step();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("t4_after_flush", bus.out_valid, 0);
    step();
    chk("t4_still_empty", bus.out_valid, 0);
    send(64'd3, 64'd4, 1'b0, 4'd3); step();
    bus.in_valid = 1'b0; step();
    chk("t4_c_valid", bus.out_valid, 1);
    chk("t4_c_result", bus.out_result, 64'd7);
    chk("t4_c_tag", bus.out_tag, 3);
    step(); step();
    chk("t4_count", dlv_res.size(), 1);

    // T5: reset with both stages occupied
    clear_dlv();
    bus.out_ready = 1'b0;
    send(64'h55, 64'h22, 1'b0, 4'd4); step();
    send(64'h66, 64'h11, 1'b1, 4'd5); step();
    bus.in_valid = 1'b0;
    reset = 1'b1; step();
    reset = 1'b0; #1;
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_out_result", bus.out_result, 0);
    chk("t5_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    step(); step(); step();
    chk("t5_no_output", dlv_res.size(), 0);

    // T6: random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 4'($urandom));
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      flush         = ($urandom % 32) == 0;
      step();
    end
    bus.in_valid = 1'b0; flush = 1'b0; bus.out_ready = 1'b1;
    step(); step(); step(); step();
    chk("t6_drained", mq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
